// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dct_pkg
//  Description : Shared definitions for the DCT transpose path: block
//                dimension, index width, bank identifier type and a bank
//                one-hot helper. Used by the transpose controller, the
//                transpose buffer and the column-DCT wrapper.
//  Revision    : 1.0  initial release
// ============================================================================
package dct_pkg;

    localparam int DCT_N     = 8;
    localparam int DCT_IDX_W = 3;

    // One-bit identifier of a transpose line-buffer bank.
    typedef logic bank_t;

    localparam bank_t BANK0 = 1'b0;
    localparam bank_t BANK1 = 1'b1;

    // Strobe vector with only the bit of bank b set.
    function automatic logic [1:0] bank_onehot(input bank_t b);
        return (b == BANK1) ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct_bank_flag.sv
`default_nettype none
// ============================================================================
//  Module      : dct_bank_flag
//  Description : Occupancy flag for one transpose bank. Holds "full" (the
//                bank carries a complete block waiting to be read) and
//                "last" (that block is the final block of the frame).
//  Ports       : i_clk       clock
//                i_rst       asynchronous active-low reset
//                i_set       bank just received its closing row
//                i_set_last  value captured into "last" on i_set
//                i_clr       final column of the bank was just issued
//                o_full      bank holds an unread block
//                o_last      held block ends the frame
//  Revision    : 1.0  initial release
// ============================================================================
module dct_bank_flag (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_set,
    input  logic i_set_last,
    input  logic i_clr,
    output logic o_full,
    output logic o_last
);

    logic full_q, full_d;
    logic last_q, last_d;

    // Set wins over clear. Writes need an empty bank and reads a full one,
    // so both strobes never target the same bank in one cycle.
    always_comb begin
        full_d = full_q;
        last_d = last_q;
        if (i_clr) begin
            full_d = 1'b0;
            last_d = 1'b0;
        end
        if (i_set) begin
            full_d = 1'b1;
            last_d = i_set_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            full_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            full_q <= full_d;
            last_q <= last_d;
        end
    end

    assign o_full = full_q;
    assign o_last = last_q;

endmodule
`default_nettype wire

// File: rtl/dct_transpose_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dct_transpose_ctrl
//  Description : Ping-pong scheduler for the two 8x8 transpose banks between
//                the row-DCT and the column-DCT. Rows are written into the
//                free bank under a valid/ready handshake; columns are read
//                from the full bank with downstream backpressure. Pulses
//                block/frame completion when the final column is accepted.
//  Ports       : i_clk, i_rst (async active-low)
//                i_valid/i_last/o_ready      upstream row handshake
//                o_wr_en/o_wr_row            bank write strobe and row index
//                o_rd_en/o_rd_col            bank read strobe and column index
//                o_rd_sel/o_valid/i_ready    downstream column handshake
//                o_block_done/o_frame_done   completion pulses
//                o_err                       sticky early-i_last error
//  Revision    : 1.0  initial release
// ============================================================================
module dct_transpose_ctrl
    import dct_pkg::*;
#(
    parameter int N     = DCT_N,
    parameter int IDX_W = DCT_IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_last,
    output logic             o_ready,
    output logic [1:0]       o_wr_en,
    output logic [IDX_W-1:0] o_wr_row,
    output logic [1:0]       o_rd_en,
    output logic [IDX_W-1:0] o_rd_col,
    output logic             o_rd_sel,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_block_done,
    output logic             o_frame_done,
    output logic             o_err
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);

    bank_t            wb_q, wb_d;
    bank_t            rb_q, rb_d;
    logic [IDX_W-1:0] wr_row_q, wr_row_d;
    logic [IDX_W-1:0] rd_col_q, rd_col_d;
    logic             valid_q, valid_d;
    bank_t            rd_sel_q, rd_sel_d;
    logic             blk_pend_q, blk_pend_d;
    logic             frm_pend_q, frm_pend_d;
    logic             err_q, err_d;

    logic [1:0]       w_full;
    logic [1:0]       w_last;
    logic [1:0]       w_set;
    logic [1:0]       w_clr;
    logic             w_wfire;
    logic             w_wr_close;
    logic             w_rfire;
    logic             w_rd_close;
    logic             w_accept;

    assign w_wfire    = i_valid & ~w_full[wb_q];
    assign w_wr_close = w_wfire & ((wr_row_q == c_last_idx) | i_last);
    // A new column may be issued when the output register is empty or is
    // being emptied this cycle.
    assign w_rfire    = w_full[rb_q] & (~valid_q | i_ready);
    assign w_rd_close = w_rfire & (rd_col_q == c_last_idx);
    assign w_accept   = valid_q & i_ready;

    assign w_set = w_wr_close ? bank_onehot(wb_q) : 2'b00;
    assign w_clr = w_rd_close ? bank_onehot(rb_q) : 2'b00;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            dct_bank_flag u_flag (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_set      (w_set[b]),
                .i_set_last (i_last),
                .i_clr      (w_clr[b]),
                .o_full     (w_full[b]),
                .o_last     (w_last[b])
            );
        end
    endgenerate

    always_comb begin
        wb_d       = wb_q;
        rb_d       = rb_q;
        wr_row_d   = wr_row_q;
        rd_col_d   = rd_col_q;
        rd_sel_d   = rd_sel_q;
        blk_pend_d = blk_pend_q;
        frm_pend_d = frm_pend_q;
        err_d      = err_q;

        if (w_wfire) begin
            if (w_wr_close) begin
                wr_row_d = '0;
                wb_d     = ~wb_q;
            end else begin
                wr_row_d = wr_row_q + 1'b1;
            end
            // Early i_last closes the bank with stale rows left behind.
            if (i_last && (wr_row_q != c_last_idx)) begin
                err_d = 1'b1;
            end
        end

        if (w_rfire) begin
            if (w_rd_close) begin
                rd_col_d = '0;
                rb_d     = ~rb_q;
            end else begin
                rd_col_d = rd_col_q + 1'b1;
            end
        end

        // Output stage holds while stalled and reloads on every issue.
        valid_d = w_rfire | (valid_q & ~i_ready);

        // Completion flags travel with the column they belong to, so the
        // pulses line up with downstream acceptance of the final column.
        if (w_rfire) begin
            rd_sel_d   = rb_q;
            blk_pend_d = w_rd_close;
            frm_pend_d = w_rd_close & w_last[rb_q];
        end else if (w_accept) begin
            blk_pend_d = 1'b0;
            frm_pend_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wb_q       <= BANK0;
            rb_q       <= BANK0;
            wr_row_q   <= '0;
            rd_col_q   <= '0;
            valid_q    <= 1'b0;
            rd_sel_q   <= BANK0;
            blk_pend_q <= 1'b0;
            frm_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wr_row_q   <= wr_row_d;
            rd_col_q   <= rd_col_d;
            valid_q    <= valid_d;
            rd_sel_q   <= rd_sel_d;
            blk_pend_q <= blk_pend_d;
            frm_pend_q <= frm_pend_d;
            err_q      <= err_d;
        end
    end

    assign o_ready      = ~w_full[wb_q];
    assign o_wr_en      = w_wfire ? bank_onehot(wb_q) : 2'b00;
    assign o_wr_row     = wr_row_q;
    assign o_rd_en      = w_rfire ? bank_onehot(rb_q) : 2'b00;
    assign o_rd_col     = rd_col_q;
    assign o_rd_sel     = rd_sel_q;
    assign o_valid      = valid_q;
    assign o_block_done = w_accept & blk_pend_q;
    assign o_frame_done = w_accept & frm_pend_q;
    assign o_err        = err_q;

    a_no_wr_rd_same_bank: assert property (@(posedge i_clk) disable iff (!i_rst)
        (o_wr_en & o_rd_en) == 2'b00);
    a_wr_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst)
        $onehot0(o_wr_en));
    a_rd_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst)
        $onehot0(o_rd_en));

endmodule
`default_nettype wire

// File: tb/tb_dct_transpose_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dct_transpose_ctrl
//  Description : Self-checking bench for dct_transpose_ctrl. A queue-based
//                block model predicts every output each cycle; directed
//                scenarios pin latency, throughput, stalls, frame/error
//                handling and asynchronous reset with literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dct_transpose_ctrl;

    logic       i_clk;
    logic       i_rst;
    logic       i_valid;
    logic       i_last;
    logic       o_ready;
    logic [1:0] o_wr_en;
    logic [2:0] o_wr_row;
    logic [1:0] o_rd_en;
    logic [2:0] o_rd_col;
    logic       o_rd_sel;
    logic       o_valid;
    logic       i_ready;
    logic       o_block_done;
    logic       o_frame_done;
    logic       o_err;

    dct_transpose_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_last       (i_last),
        .o_ready      (o_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_row     (o_wr_row),
        .o_rd_en      (o_rd_en),
        .o_rd_col     (o_rd_col),
        .o_rd_sel     (o_rd_sel),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_block_done (o_block_done),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a queue of completed blocks awaiting read, plus the column
    // currently presented downstream.
    // ------------------------------------------------------------------
    typedef struct {
        logic bank;
        logic last;
    } blk_t;

    blk_t m_q[$];
    int   m_wr_row = 0;
    int   m_wr_blk = 0;
    int   m_rd_col = 0;
    logic m_pv     = 1'b0;
    logic m_pbank  = 1'b0;
    int   m_pcol   = 0;
    logic m_plast  = 1'b0;
    logic m_err    = 1'b0;

    // Observed statistics for the directed checks.
    int cyc = 0;
    int n_wr0 = 0, n_wr1 = 0, n_rd = 0, n_bd = 0, n_fd = 0, n_fdbd = 0, n_stall = 0;
    int run = 0, last_run = 0;
    int cyc_wr7 = 0, cyc_rd0 = 0, cyc_vrise = 0;
    logic prev_valid = 1'b0;

    initial begin
        logic       e_ready, e_wf, e_rf, e_bd, e_fd;
        logic [1:0] e_wr, e_rd;
        blk_t       nb;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (!i_rst) begin
                chk("rst_ready",  o_ready,      1);
                chk("rst_wr_en",  o_wr_en,      0);
                chk("rst_rd_en",  o_rd_en,      0);
                chk("rst_valid",  o_valid,      0);
                chk("rst_rd_sel", o_rd_sel,     0);
                chk("rst_bdone",  o_block_done, 0);
                chk("rst_fdone",  o_frame_done, 0);
                chk("rst_err",    o_err,        0);
                m_q.delete();
                m_wr_row = 0; m_wr_blk = 0; m_rd_col = 0;
                m_pv = 1'b0; m_err = 1'b0;
                run = 0; prev_valid = 1'b0;
            end else begin
                e_ready = (m_q.size() < 2);
                e_wf    = i_valid && e_ready;
                e_rf    = (m_q.size() > 0) && (!m_pv || i_ready);
                e_wr    = e_wf ? (((m_wr_blk % 2) == 1) ? 2'b10 : 2'b01) : 2'b00;
                e_rd    = 2'b00;
                if (e_rf) e_rd = m_q[0].bank ? 2'b10 : 2'b01;
                e_bd    = m_pv && i_ready && (m_pcol == 7);
                e_fd    = e_bd && m_plast;

                chk("ready", o_ready, e_ready);
                chk("wr_en", o_wr_en, e_wr);
                if (e_wf) chk("wr_row", o_wr_row, m_wr_row);
                chk("rd_en", o_rd_en, e_rd);
                if (e_rf) chk("rd_col", o_rd_col, m_rd_col);
                chk("valid", o_valid, m_pv);
                if (m_pv) chk("rd_sel", o_rd_sel, m_pbank);
                chk("block_done", o_block_done, e_bd);
                chk("frame_done", o_frame_done, e_fd);
                chk("err", o_err, m_err);

                // statistics from observed outputs
                if (o_wr_en == 2'b01) n_wr0++;
                if (o_wr_en == 2'b10) n_wr1++;
                if (o_wr_en != 2'b00 && o_wr_row == 3'd7) cyc_wr7 = cyc;
                if (o_rd_en != 2'b00) n_rd++;
                if (o_rd_en != 2'b00 && o_rd_col == 3'd0) cyc_rd0 = cyc;
                if (o_valid && !prev_valid) cyc_vrise = cyc;
                if (o_block_done) n_bd++;
                if (o_frame_done) n_fd++;
                if (o_frame_done && o_block_done) n_fdbd++;
                if (i_valid && !o_ready) n_stall++;
                if (o_valid) run++;
                else begin
                    if (run > 0) last_run = run;
                    run = 0;
                end
                prev_valid = o_valid;

                // advance the model across the coming clock edge
                if (e_rf) begin
                    m_pv    = 1'b1;
                    m_pbank = m_q[0].bank;
                    m_pcol  = m_rd_col;
                    m_plast = m_q[0].last;
                    if (m_rd_col == 7) begin
                        void'(m_q.pop_front());
                        m_rd_col = 0;
                    end else begin
                        m_rd_col++;
                    end
                end else if (m_pv && i_ready) begin
                    m_pv = 1'b0;
                end
                if (e_wf) begin
                    if (i_last && m_wr_row != 7) m_err = 1'b1;
                    if (m_wr_row == 7 || i_last) begin
                        nb.bank = ((m_wr_blk % 2) == 1);
                        nb.last = i_last;
                        m_q.push_back(nb);
                        m_wr_blk++;
                        m_wr_row = 0;
                    end else begin
                        m_wr_row++;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    int b_wr0, b_wr1, b_rd, b_bd, b_fd, b_fdbd, b_stall;

    task automatic snap();
        b_wr0 = n_wr0; b_wr1 = n_wr1; b_rd = n_rd; b_bd = n_bd;
        b_fd = n_fd; b_fdbd = n_fdbd; b_stall = n_stall;
    endtask

    task automatic do_reset();
        i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b1;
    endtask

    task automatic send_rows(input int n, input int last_at);
        int   i = 0;
        int   guard = 0;
        logic acc;
        while (i < n && guard < 500) begin
            i_valid = 1'b1;
            i_last  = (i == last_at);
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            if (acc) i++;
            guard++;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        if (guard >= 500) chk("send_timeout", 1, 0);
    endtask

    task automatic drain();
        int idle = 0;
        int guard = 0;
        while (idle < 3 && guard < 300) begin
            @(negedge i_clk);
            if (!o_valid && o_rd_en == 2'b00) idle++;
            else idle = 0;
            guard++;
        end
        if (guard >= 300) chk("drain_timeout", 1, 0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int k;
        i_rst = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b1;

        // 1: one block, latency and single completion
        snap();
        send_rows(8, -1);
        drain();
        chk("t1_wr_bank0", n_wr0 - b_wr0, 8);
        chk("t1_wr_bank1", n_wr1 - b_wr1, 0);
        chk("t1_rd_count", n_rd - b_rd, 8);
        chk("t1_block_done", n_bd - b_bd, 1);
        chk("t1_frame_done", n_fd - b_fd, 0);
        chk("t1_valid_run", last_run, 8);
        chk("t1_rd_latency", cyc_rd0 - cyc_wr7, 1);
        chk("t1_valid_latency", cyc_vrise - cyc_wr7, 2);

        // 2: four blocks streamed without bubbles
        do_reset();
        snap();
        send_rows(32, -1);
        drain();
        chk("t2_wr_bank0", n_wr0 - b_wr0, 16);
        chk("t2_wr_bank1", n_wr1 - b_wr1, 16);
        chk("t2_stalls", n_stall - b_stall, 0);
        chk("t2_block_done", n_bd - b_bd, 4);
        chk("t2_valid_run", last_run, 32);

        // 3: downstream stalled, both banks fill
        do_reset();
        snap();
        i_ready = 1'b0;
        send_rows(16, -1);
        for (int s = 0; s < 3; s++) begin
            @(negedge i_clk);
            chk("t3_ready_low", o_ready, 0);
            chk("t3_valid_held", o_valid, 1);
            chk("t3_rd_col_frozen", o_rd_col, 1);
            chk("t3_no_issue", o_rd_en, 0);
            chk("t3_sel", o_rd_sel, 0);
        end
        @(posedge i_clk);
        #1 i_ready = 1'b1;
        k = 0;
        while (k < 50) begin
            @(negedge i_clk);
            if (o_ready) break;
            k++;
        end
        chk("t3_ready_resume", k, 7);
        drain();
        chk("t3_rd_count", n_rd - b_rd, 16);
        chk("t3_block_done", n_bd - b_bd, 2);

        // 4: frame ends on row 7 of the second block
        do_reset();
        snap();
        send_rows(8, -1);
        send_rows(8, 7);
        drain();
        chk("t4_block_done", n_bd - b_bd, 2);
        chk("t4_frame_done", n_fd - b_fd, 1);
        chk("t4_frame_with_block", n_fdbd - b_fdbd, 1);
        chk("t4_err", o_err, 0);

        // 5: early i_last on row 4
        do_reset();
        snap();
        send_rows(5, 4);
        drain();
        chk("t5_err", o_err, 1);
        chk("t5_rd_count", n_rd - b_rd, 8);
        chk("t5_frame_done", n_fd - b_fd, 1);
        chk("t5_block_done", n_bd - b_bd, 1);
        snap();
        send_rows(8, -1);
        drain();
        chk("t5_err_sticky", o_err, 1);
        chk("t5_no_frame", n_fd - b_fd, 0);

        // 6: asynchronous reset in the middle of a read
        do_reset();
        send_rows(8, -1);
        k = 0;
        while (k < 50) begin
            @(negedge i_clk);
            if (o_rd_en != 2'b00 && o_rd_col == 3'd3) break;
            k++;
        end
        chk("t6_reach_col3", (k < 50), 1);
        snap();
        #2 i_rst = 1'b0;
        #1;
        chk("t6_async_valid", o_valid, 0);
        chk("t6_async_ready", o_ready, 1);
        chk("t6_async_rd_en", o_rd_en, 0);
        chk("t6_async_rd_col", o_rd_col, 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        send_rows(8, -1);
        drain();
        chk("t6_wr_bank0", n_wr0 - b_wr0, 8);
        chk("t6_wr_bank1", n_wr1 - b_wr1, 0);
        chk("t6_block_done", n_bd - b_bd, 1);
        chk("t6_frame_done", n_fd - b_fd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
